// File: rtl/axi_pkg.sv
// Shared AXI encodings and FSM state types for the on-chip AXI4 slave memory.
package axi_pkg;

    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE = 2'b00,
        W_DATA = 2'b01,
        W_RESP = 2'b10
    } w_state_t;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_t;

    function automatic logic [1:0] resp_of(input logic err);
        return err ? RESP_SLVERR : RESP_OKAY;
    endfunction

endpackage

// File: rtl/axi_sdp_ram.sv
// Simple dual-port RAM: byte-enabled write port A, registered read port B.
// Contents are deliberately not reset so the array maps onto block RAM.
module axi_sdp_ram #(
    parameter int DEPTH = 4096,
    parameter int WIDTH = 256,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic               i_clk,
    input  logic               i_we,
    input  logic [IDX_W-1:0]   i_waddr,
    input  logic [WIDTH-1:0]   i_wdata,
    input  logic [WIDTH/8-1:0] i_wbe,
    input  logic               i_re,
    input  logic [IDX_W-1:0]   i_raddr,
    output logic [WIDTH-1:0]   o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    // Port A: byte-lane write
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int b = 0; b < WIDTH/8; b++) begin
                if (i_wbe[b]) begin
                    r_mem[i_waddr][b*8 +: 8] <= i_wdata[b*8 +: 8];
                end
            end
        end
    end

    // Port B: registered read; a same-cycle write to the same word returns old data
    always_ff @(posedge i_clk) begin
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/axi_slave_mem.sv
// AXI4 INCR-burst slave backed by on-chip RAM; beat-indexed addressing,
// independent read and write engines with one outstanding burst each.
module axi_slave_mem
    import axi_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int AXI_WIDTH  = 256,
    parameter int ID_WIDTH   = 4,
    parameter int LEN_WIDTH  = 8,
    parameter int MEM_DEPTH  = 4096
) (
    input  logic                   ACLK,
    input  logic                   ARESETN,
    input  logic [ID_WIDTH-1:0]    S_AXI_AWID,
    input  logic [ADDR_WIDTH-1:0]  S_AXI_AWADDR,
    input  logic [LEN_WIDTH-1:0]   S_AXI_AWLEN,
    input  logic [2:0]             S_AXI_AWSIZE,
    input  logic [1:0]             S_AXI_AWBURST,
    input  logic                   S_AXI_AWVALID,
    output logic                   S_AXI_AWREADY,
    input  logic [AXI_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [AXI_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                   S_AXI_WLAST,
    input  logic                   S_AXI_WVALID,
    output logic                   S_AXI_WREADY,
    output logic [ID_WIDTH-1:0]    S_AXI_BID,
    output logic [1:0]             S_AXI_BRESP,
    output logic                   S_AXI_BVALID,
    input  logic                   S_AXI_BREADY,
    input  logic [ID_WIDTH-1:0]    S_AXI_ARID,
    input  logic [ADDR_WIDTH-1:0]  S_AXI_ARADDR,
    input  logic [LEN_WIDTH-1:0]   S_AXI_ARLEN,
    input  logic [2:0]             S_AXI_ARSIZE,
    input  logic [1:0]             S_AXI_ARBURST,
    input  logic                   S_AXI_ARVALID,
    output logic                   S_AXI_ARREADY,
    output logic [ID_WIDTH-1:0]    S_AXI_RID,
    output logic [AXI_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]             S_AXI_RRESP,
    output logic                   S_AXI_RLAST,
    output logic                   S_AXI_RVALID,
    input  logic                   S_AXI_RREADY
);

    localparam int                   IDX_W    = $clog2(MEM_DEPTH);
    localparam logic [ADDR_WIDTH:0]  DEPTH_A  = (ADDR_WIDTH+1)'(MEM_DEPTH);
    localparam logic [ADDR_WIDTH:0]  ADDR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [LEN_WIDTH-1:0] LEN_ZERO = {LEN_WIDTH{1'b0}};
    localparam logic [LEN_WIDTH-1:0] LEN_ONE  = {{(LEN_WIDTH-1){1'b0}}, 1'b1};

    // Size fields are ignored: every beat is full width.
    logic w_unused;
    assign w_unused = ^{S_AXI_AWSIZE, S_AXI_ARSIZE};

    // ---------------- write engine ----------------
    w_state_t              r_wstate, w_wstate_next;
    logic                  r_awready, r_wready, r_bvalid;
    logic [1:0]            r_bresp;
    logic [ID_WIDTH-1:0]   r_wid;
    logic [ADDR_WIDTH:0]   r_waddr;
    logic [LEN_WIDTH-1:0]  r_wlen, r_wbeat;
    logic                  r_wburst_ok, r_werr;
    logic                  w_aw_hs, w_w_hs, w_b_hs;
    logic                  w_wlast_beat, w_wbeat_ok, w_werr_next, w_ram_we;

    assign w_aw_hs      = r_awready && S_AXI_AWVALID;
    assign w_w_hs       = r_wready && S_AXI_WVALID;
    assign w_b_hs       = r_bvalid && S_AXI_BREADY;
    assign w_wlast_beat = (r_wbeat == r_wlen);
    assign w_wbeat_ok   = (r_waddr < DEPTH_A) && r_wburst_ok;
    // Burst length is defined by AWLEN; a misplaced or missing WLAST only flags an error.
    assign w_werr_next  = r_werr || !w_wbeat_ok || (S_AXI_WLAST != w_wlast_beat);
    assign w_ram_we     = w_w_hs && w_wbeat_ok;

    // Write FSM next-state
    always_comb begin
        w_wstate_next = r_wstate;
        case (r_wstate)
            W_IDLE: begin
                if (w_aw_hs) w_wstate_next = W_DATA;
                else         w_wstate_next = W_IDLE;
            end
            W_DATA: begin
                if (w_w_hs && w_wlast_beat) w_wstate_next = W_RESP;
                else                        w_wstate_next = W_DATA;
            end
            W_RESP: begin
                if (w_b_hs) w_wstate_next = W_IDLE;
                else        w_wstate_next = W_RESP;
            end
            default: w_wstate_next = W_IDLE;
        endcase
    end

    // Write FSM state and registered handshake outputs
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_wstate  <= W_IDLE;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
        end else begin
            r_wstate  <= w_wstate_next;
            r_awready <= (w_wstate_next == W_IDLE);
            r_wready  <= (w_wstate_next == W_DATA);
            r_bvalid  <= (w_wstate_next == W_RESP);
        end
    end

    // Write burst context, beat counter, sticky error and response code
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_wid       <= {ID_WIDTH{1'b0}};
            r_waddr     <= {(ADDR_WIDTH+1){1'b0}};
            r_wlen      <= LEN_ZERO;
            r_wbeat     <= LEN_ZERO;
            r_wburst_ok <= 1'b0;
            r_werr      <= 1'b0;
            r_bresp     <= RESP_OKAY;
        end else if (w_aw_hs) begin
            r_wid       <= S_AXI_AWID;
            r_waddr     <= {1'b0, S_AXI_AWADDR};
            r_wlen      <= S_AXI_AWLEN;
            r_wbeat     <= LEN_ZERO;
            r_wburst_ok <= (S_AXI_AWBURST == BURST_INCR);
            r_werr      <= 1'b0;
        end else if (w_w_hs) begin
            r_waddr <= r_waddr + ADDR_ONE;
            r_wbeat <= r_wbeat + LEN_ONE;
            r_werr  <= w_werr_next;
            if (w_wlast_beat) r_bresp <= resp_of(w_werr_next);
        end
    end

    // ---------------- read engine ----------------
    r_state_t              r_rstate, w_rstate_next;
    logic                  r_arready, r_rvalid, r_rlast, r_rzero, r_rburst_ok;
    logic [1:0]            r_rresp;
    logic [ID_WIDTH-1:0]   r_rid;
    logic [ADDR_WIDTH:0]   r_raddr;
    logic [LEN_WIDTH-1:0]  r_rlen, r_rbeat;
    logic                  w_ar_hs, w_r_hs, w_r_adv, w_rd_ok, w_ram_re;
    logic [ADDR_WIDTH:0]   w_rd_addr;
    logic [AXI_WIDTH-1:0]  w_ram_q;

    assign w_ar_hs = r_arready && S_AXI_ARVALID;
    assign w_r_hs  = r_rvalid && S_AXI_RREADY;
    assign w_r_adv = (r_rstate == R_DATA) && (!r_rvalid || S_AXI_RREADY) && !r_rlast;

    // Beat 0 is fetched on the AR handshake itself so RVALID follows one cycle later.
    always_comb begin
        w_rd_addr = r_raddr;
        w_rd_ok   = 1'b0;
        if (w_ar_hs) begin
            w_rd_addr = {1'b0, S_AXI_ARADDR};
            w_rd_ok   = ({1'b0, S_AXI_ARADDR} < DEPTH_A) && (S_AXI_ARBURST == BURST_INCR);
        end else begin
            w_rd_addr = r_raddr;
            w_rd_ok   = (r_raddr < DEPTH_A) && r_rburst_ok;
        end
    end

    assign w_ram_re = (w_ar_hs || w_r_adv) && w_rd_ok;

    // Read FSM next-state
    always_comb begin
        w_rstate_next = r_rstate;
        case (r_rstate)
            R_IDLE: begin
                if (w_ar_hs) w_rstate_next = R_DATA;
                else         w_rstate_next = R_IDLE;
            end
            R_DATA: begin
                if (w_r_hs && r_rlast) w_rstate_next = R_IDLE;
                else                   w_rstate_next = R_DATA;
            end
            default: w_rstate_next = R_IDLE;
        endcase
    end

    // Read FSM state and registered ARREADY
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b0;
        end else begin
            r_rstate  <= w_rstate_next;
            r_arready <= (w_rstate_next == R_IDLE);
        end
    end

    // Read burst context and per-beat R channel registers (held while stalled)
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_rid       <= {ID_WIDTH{1'b0}};
            r_raddr     <= {(ADDR_WIDTH+1){1'b0}};
            r_rlen      <= LEN_ZERO;
            r_rbeat     <= LEN_ZERO;
            r_rburst_ok <= 1'b0;
            r_rvalid    <= 1'b0;
            r_rlast     <= 1'b0;
            r_rresp     <= RESP_OKAY;
            r_rzero     <= 1'b1;
        end else if (w_ar_hs) begin
            r_rid       <= S_AXI_ARID;
            r_raddr     <= {1'b0, S_AXI_ARADDR} + ADDR_ONE;
            r_rlen      <= S_AXI_ARLEN;
            r_rbeat     <= LEN_ZERO;
            r_rburst_ok <= (S_AXI_ARBURST == BURST_INCR);
            r_rvalid    <= 1'b1;
            r_rlast     <= (S_AXI_ARLEN == LEN_ZERO);
            r_rresp     <= resp_of(!w_rd_ok);
            r_rzero     <= !w_rd_ok;
        end else if (w_r_adv) begin
            r_raddr  <= r_raddr + ADDR_ONE;
            r_rbeat  <= r_rbeat + LEN_ONE;
            r_rvalid <= 1'b1;
            r_rlast  <= ((r_rbeat + LEN_ONE) == r_rlen);
            r_rresp  <= resp_of(!w_rd_ok);
            r_rzero  <= !w_rd_ok;
        end else if (w_r_hs && r_rlast) begin
            r_rvalid <= 1'b0;
            r_rlast  <= 1'b0;
        end
    end

    axi_sdp_ram #(
        .DEPTH (MEM_DEPTH),
        .WIDTH (AXI_WIDTH),
        .IDX_W (IDX_W)
    ) u_ram (
        .i_clk   (ACLK),
        .i_we    (w_ram_we),
        .i_waddr (r_waddr[IDX_W-1:0]),
        .i_wdata (S_AXI_WDATA),
        .i_wbe   (S_AXI_WSTRB),
        .i_re    (w_ram_re),
        .i_raddr (w_rd_addr[IDX_W-1:0]),
        .o_rdata (w_ram_q)
    );

    assign S_AXI_AWREADY = r_awready;
    assign S_AXI_WREADY  = r_wready;
    assign S_AXI_BVALID  = r_bvalid;
    assign S_AXI_BRESP   = r_bresp;
    assign S_AXI_BID     = r_wid;
    assign S_AXI_ARREADY = r_arready;
    assign S_AXI_RVALID  = r_rvalid;
    assign S_AXI_RLAST   = r_rlast;
    assign S_AXI_RRESP   = r_rresp;
    assign S_AXI_RID     = r_rid;
    assign S_AXI_RDATA   = r_rzero ? {AXI_WIDTH{1'b0}} : w_ram_q;

endmodule
